// File: rtl/pico_uart_tx_responder.sv
// pico_uart_tx_responder: PicoRV32 bus responder feeding a TX FIFO drained by an 8N1 UART serializer
module pico_uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int FIFO_DEPTH = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic [7:0]  out_byte,
  output logic        out_byte_en
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [15:0] div, period, cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic hit, wr, data_wr, div_wr, full, empty, stall, accept, enq, deq, bit_end, busy;
  logic [1:0] off;
  logic [31:0] status, rdata_c;
  logic unused;
  assign unused = ^{mem_addr[1:0], mem_wdata[31:16]};
  assign off = mem_addr[3:2];
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign busy = state != IDLE;
  assign hit = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]) & ~mem_ready;
  assign wr = ~mem_instr & (|mem_wstrb);
  assign data_wr = hit & wr & (off == 2'd0) & mem_wstrb[0];
  assign div_wr = hit & wr & (off == 2'd2);
  assign stall = data_wr & full;
  assign accept = hit & ~stall;
  assign enq = data_wr & ~full;
  assign bit_end = cnt == period - 16'd1;
  assign deq = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  // Read mux: STATUS packs busy/full/empty and the FIFO fill level
  always_comb begin
    status = '0;
    status[0] = busy;
    status[1] = full;
    status[2] = empty;
    status[8 +: CW] = count;
    rdata_c = wr ? '0 : (off == 2'd1) ? status : (off == 2'd2) ? {16'h0, div} : '0;
  end
  // Bus side: registered single-cycle ready, DIV byte writes and enqueue mirror
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      div <= DEFAULT_DIV;
      out_byte <= '0;
      out_byte_en <= 1'b0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= accept ? rdata_c : '0;
      out_byte_en <= enq;
      if (enq) out_byte <= mem_wdata[7:0];
      if (div_wr & mem_wstrb[0]) div[7:0] <= mem_wdata[7:0];
      if (div_wr & mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
    end
  // FIFO pointers and fill level; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + AW'(1);
      if (deq) rptr <= rptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  // FIFO storage needs no reset; the count decides what is valid
  always_ff @(posedge clk)
    if (enq) fifo[wptr] <= mem_wdata[7:0];
  // Serializer: start, 8 data bits LSB first, stop; a pending byte chains straight into START
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      uart_tx <= 1'b1;
      period <= 16'd2;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
    end else if (deq) begin
      state <= START;
      uart_tx <= 1'b0;
      shreg <= fifo[rptr];
      period <= (div < 16'd2) ? 16'd2 : div;
      cnt <= '0;
    end else if (state == IDLE) begin
      uart_tx <= 1'b1;
    end else if (!bit_end) begin
      cnt <= cnt + 16'd1;
    end else begin
      cnt <= '0;
      case (state)
        START: begin
          state <= DATA;
          bit_idx <= '0;
          uart_tx <= shreg[0];
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            state <= STOP;
            uart_tx <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            shreg <= shreg >> 1;
            uart_tx <= shreg[1];
          end
        end
        default: begin
          state <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_pico_uart_tx_responder.sv
// tb_pico_uart_tx_responder: directed bench with read and UART frame scoreboards
module tb_pico_uart_tx_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic clk = 1'b0, resetn = 1'b0, mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0] mem_wstrb = '0;
  logic mem_ready, uart_tx, out_byte_en;
  logic [31:0] mem_rdata;
  logic [7:0] out_byte;
  int checks = 0, errors = 0, cyc = 0, bit_p = 4, lat = 0, rc = 0, r = 0, pulses = 0;
  logic mon_en = 1'b0, mon_ok, obe;
  logic [7:0] mon_b, mon_exp, ob;
  logic [31:0] seen;
  logic [31:0] q_rd [$];
  logic [7:0] q_tx [$];
  bit tx_hist [65536];

  pico_uart_tx_responder dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .uart_tx(uart_tx),
    .out_byte(out_byte), .out_byte_en(out_byte_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #2 tx_hist[cyc[15:0]] = uart_tx;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ins,
                     input logic chk, input logic [31:0] exp, input string tag, output int l);
    logic [31:0] e;
    if (chk) q_rd.push_back(exp);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    l = 0;
    do begin @(negedge clk); l++; end while (!mem_ready && l < 3000);
    check({tag, "_ready"}, {31'b0, mem_ready}, 32'd1);
    rc = cyc; ob = out_byte; obe = out_byte_en;
    if (chk) begin
      e = q_rd.pop_front();
      check({tag, "_rdata"}, mem_rdata, e);
    end
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {30'b0, mem_ready, out_byte_en}, 32'd0);
  endtask

  task automatic wr_data(input logic [7:0] b, input string tag);
    if (mon_en) q_tx.push_back(b);
    bus(BASE, {24'h0, b}, 4'b0001, 1'b0, 1'b0, '0, tag, lat);
    check({tag, "_obe"}, {31'b0, obe}, 32'd1);
    check({tag, "_ob"}, {24'b0, ob}, {24'b0, b});
  endtask

  task automatic check_wave(input string tag, input int base, input logic [7:0] b, input int p);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int j = 0; j < 10 * p; j++)
      check(tag, {31'b0, tx_hist[base + 1 + j]}, {31'b0, f[j / p]});
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en && resetn && uart_tx === 1'b0) begin
      repeat (bit_p / 2) @(negedge clk);
      mon_ok = ~uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (bit_p) @(negedge clk);
        mon_b[i] = uart_tx;
      end
      repeat (bit_p) @(negedge clk);
      mon_ok = mon_ok & uart_tx;
      if (q_tx.size() == 0) check("uart_extra_frame", {24'b0, mon_b}, 32'hFFFF_FFFF);
      else begin
        mon_exp = q_tx.pop_front();
        check("uart_frame", {23'b0, mon_ok, mon_b}, {23'b0, 1'b1, mon_exp});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_ob", {23'b0, out_byte_en, out_byte}, 32'd0);
    resetn = 1'b1;
    bus(BASE + 4, '0, 4'h0, 1'b0, 1'b1, 32'h0000_0004, "status_rst", lat);
    check("status_lat", lat, 32'd1);
    check("idle_tx", {31'b0, uart_tx}, 32'd1);
    bus(BASE + 8, '0, 4'h0, 1'b0, 1'b1, 32'd234, "div_rst", lat);
    bus(BASE + 0, '0, 4'h0, 1'b0, 1'b1, 32'd0, "data_rd", lat);
    bus(BASE + 12, '0, 4'h0, 1'b0, 1'b1, 32'd0, "off3_rd", lat);
    bus(BASE + 8, 32'hFFFF_1234, 4'b0011, 1'b0, 1'b0, '0, "div_wr", lat);
    bus(BASE + 8, '0, 4'h0, 1'b0, 1'b1, 32'h0000_1234, "div_rd", lat);
    bus(BASE + 8, 32'h0000_AB00, 4'b0010, 1'b0, 1'b0, '0, "div_wr_hi", lat);
    bus(BASE + 8, '0, 4'h0, 1'b0, 1'b1, 32'h0000_AB34, "div_rd_hi", lat);
    bus(BASE + 8, 32'd7, 4'hF, 1'b1, 1'b1, 32'h0000_AB34, "instr_rd", lat);
    bus(BASE + 12, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, '0, "off3_wr", lat);
    bus(BASE + 8, '0, 4'h0, 1'b0, 1'b1, 32'h0000_AB34, "div_keep", lat);

    mem_valid = 1'b1; mem_addr = BASE + 4; mem_wstrb = '0; pulses = 0; seen = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses += int'(mem_ready);
      if (mem_ready) seen = mem_rdata;
      if (i == 1) mem_valid = 1'b0;
    end
    check("hold_pulses", pulses, 32'd1);
    check("hold_rdata", seen, 32'd4);
    mem_valid = 1'b1; mem_addr = BASE + 32'h10; pulses = 0; seen = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses += int'(mem_ready);
      seen = seen | mem_rdata;
    end
    mem_valid = 1'b0;
    check("miss_pulses", pulses, 32'd0);
    check("miss_rdata", seen, 32'd0);

    bus(BASE + 8, 32'd4, 4'b0011, 1'b0, 1'b0, '0, "div4", lat);
    bit_p = 4; mon_en = 1'b1;
    wr_data(8'hA5, "a5");
    r = rc;
    while (cyc < r + 43) @(negedge clk);
    check("a5_idle_at_enq", {31'b0, tx_hist[r]}, 32'd1);
    check_wave("a5_wave", r, 8'hA5, 4);
    check("a5_idle_after", {30'b0, tx_hist[r + 41], tx_hist[r + 42]}, 32'd3);

    bus(BASE + 8, 32'd100, 4'b0011, 1'b0, 1'b0, '0, "div100", lat);
    bit_p = 100;
    for (int i = 0; i < 17; i++) begin
      wr_data(8'h30 + 8'(i), "fill");
      check("fill_lat", lat, 32'd1);
    end
    bus(BASE + 4, '0, 4'h0, 1'b0, 1'b1, 32'h0000_1003, "status_full", lat);
    wr_data(8'h41, "stall");
    check("stall_lat", lat, 32'd967);
    for (int i = 0; i < 30000 && q_tx.size() != 0; i++) @(negedge clk);
    check("drain_q", q_tx.size(), 32'd0);
    repeat (bit_p) @(negedge clk);
    bus(BASE + 4, '0, 4'h0, 1'b0, 1'b1, 32'h0000_0004, "status_drained", lat);

    bus(BASE + 8, 32'd2, 4'b0011, 1'b0, 1'b0, '0, "div2", lat);
    bit_p = 2;
    wr_data(8'h01, "b2b_1");
    r = rc;
    wr_data(8'h02, "b2b_2");
    bus(BASE + 4, '0, 4'h0, 1'b0, 1'b1, 32'h0000_0101, "status_b2b", lat);
    while (cyc < r + 43) @(negedge clk);
    check_wave("b2b_wave1", r, 8'h01, 2);
    check_wave("b2b_wave2", r + 20, 8'h02, 2);
    check("b2b_idle_after", {30'b0, tx_hist[r + 41], tx_hist[r + 42]}, 32'd3);
    bus(BASE + 4, '0, 4'h0, 1'b0, 1'b1, 32'h0000_0004, "status_b2b_done", lat);
    for (int i = 0; i < 100 && q_tx.size() != 0; i++) @(negedge clk);
    check("b2b_q", q_tx.size(), 32'd0);

    mon_en = 1'b0;
    bus(BASE + 8, 32'd4, 4'b0011, 1'b0, 1'b0, '0, "div4_rst", lat);
    wr_data(8'h00, "rst_b0");
    r = rc;
    wr_data(8'h55, "rst_b1");
    while (cyc < r + 8) @(negedge clk);
    check("mid_data_tx", {31'b0, uart_tx}, 32'd0);
    resetn = 1'b0;
    #1;
    check("async_rst_tx", {31'b0, uart_tx}, 32'd1);
    check("async_rst_ready", {31'b0, mem_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    bus(BASE + 4, '0, 4'h0, 1'b0, 1'b1, 32'h0000_0004, "status_after_rst", lat);
    bus(BASE + 8, '0, 4'h0, 1'b0, 1'b1, 32'd234, "div_after_rst", lat);
    repeat (20) @(negedge clk);
    check("flushed_tx", {31'b0, uart_tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
